// File: rtl/hex_edit_bank.sv
// Push-button hex editor for NREGS registers: per-button sync/debounce, auto-repeat,
// cursor and nibble editing with wrap-around, a one-hot blink mask and an edit pulse.
module hex_edit_bank #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NREGS      = 2,
    parameter logic [NREGS*WIDTH-1:0] INIT = {32'h12345678, 32'h87654321},
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned REP_DELAY  = 50_000_000,
    parameter int unsigned REP_RATE   = 10_000_000,
    localparam int unsigned NDIG      = WIDTH / 4,
    localparam int unsigned SW        = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int unsigned CW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             BTN,
    input  logic                   edit_en,
    input  logic [SW-1:0]          sel,
    output logic [NREGS*WIDTH-1:0] values,
    output logic [CW-1:0]          cursor,
    output logic [NDIG-1:0]        blink,
    output logic                   changed
);
    localparam int unsigned DW   = $clog2(DEB_CYCLES) + 1;
    localparam int unsigned TMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int unsigned TW   = $clog2(TMAX + 1) + 1;

    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       valid_q;
    logic [DW-1:0]    deb_cnt_q [4];
    logic [DW-1:0]    deb_cnt_d [4];
    logic [TW-1:0]    tmr_q [4];
    logic [TW-1:0]    tmr_d [4];
    logic [3:0]       level_q, level_d, rise_q, rise_d;
    logic [3:0]       arm_q, arm_d, phase_q, phase_d;
    logic [3:0]       tick, ev;

    logic [WIDTH-1:0] vals_q [NREGS];
    logic [WIDTH-1:0] vals_d [NREGS];
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [NDIG-1:0]  blink_q, blink_d;
    logic             changed_q, changed_d;
    logic [3:0]       nib;

    // A button held through reset stays disarmed until it has been seen released,
    // so the post-reset debounce of a still-held key never counts as a press.
    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            deb_cnt_d[b] = deb_cnt_q[b];
            level_d[b]   = level_q[b];
            rise_d[b]    = 1'b0;
            if (sync2_q[b] == level_q[b]) begin
                deb_cnt_d[b] = '0;
            end else if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
                level_d[b]   = sync2_q[b];
                rise_d[b]    = sync2_q[b];
                deb_cnt_d[b] = '0;
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
            end

            tick[b] = (REP_DELAY != 0) && level_q[b] &&
                      (tmr_q[b] == (phase_q[b] ? TW'(REP_RATE) : TW'(REP_DELAY)));
            tmr_d[b]   = tmr_q[b];
            phase_d[b] = phase_q[b];
            if (!level_q[b] || REP_DELAY == 0) begin
                tmr_d[b]   = '0;
                phase_d[b] = 1'b0;
            end else if (tick[b]) begin
                tmr_d[b]   = TW'(1);
                phase_d[b] = 1'b1;
            end else begin
                tmr_d[b] = tmr_q[b] + 1'b1;
            end

            arm_d[b] = arm_q[b] | (valid_q[1] & ~sync2_q[b] & ~level_q[b]);
            ev[b]    = arm_q[b] & (rise_q[b] | tick[b]);
        end
    end

    // The nibble edit reads the old cursor; the cursor move is computed separately.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            vals_d[r] = vals_q[r];
        end
        cursor_d  = cursor_q;
        changed_d = 1'b0;
        blink_d   = '0;
        nib       = '0;
        if (edit_en) begin
            if (ev[2] ^ ev[3]) begin
                for (int unsigned r = 0; r < NREGS; r++) begin
                    if (SW'(r) == sel) begin
                        nib = vals_q[r][{cursor_q, 2'b00} +: 4];
                        vals_d[r][{cursor_q, 2'b00} +: 4] = ev[2] ? nib + 4'd1 : nib - 4'd1;
                        changed_d = 1'b1;
                    end
                end
            end
            if (ev[0] && !ev[1]) begin
                cursor_d = (cursor_q == CW'(NDIG - 1)) ? '0 : cursor_q + 1'b1;
            end else if (ev[1] && !ev[0]) begin
                cursor_d = (cursor_q == '0) ? CW'(NDIG - 1) : cursor_q - 1'b1;
            end
            blink_d = NDIG'(1) << cursor_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            valid_q   <= '0;
            level_q   <= '0;
            rise_q    <= '0;
            arm_q     <= '0;
            phase_q   <= '0;
            for (int unsigned b = 0; b < 4; b++) begin
                deb_cnt_q[b] <= '0;
                tmr_q[b]     <= '0;
            end
            for (int unsigned r = 0; r < NREGS; r++) begin
                vals_q[r] <= INIT[r*WIDTH +: WIDTH];
            end
            cursor_q  <= '0;
            blink_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= BTN;
            sync2_q   <= sync1_q;
            valid_q   <= {valid_q[0], 1'b1};
            level_q   <= level_d;
            rise_q    <= rise_d;
            arm_q     <= arm_d;
            phase_q   <= phase_d;
            for (int unsigned b = 0; b < 4; b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
                tmr_q[b]     <= tmr_d[b];
            end
            for (int unsigned r = 0; r < NREGS; r++) begin
                vals_q[r] <= vals_d[r];
            end
            cursor_q  <= cursor_d;
            blink_q   <= blink_d;
            changed_q <= changed_d;
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_flat
        assign values[r*WIDTH +: WIDTH] = vals_q[r];
    end
    assign cursor  = cursor_q;
    assign blink   = blink_q;
    assign changed = changed_q;
endmodule
